crc_stream_engine: RTL and testbench
====================================

Name: crc_stream_engine

Overview:
- Parametrised, multi-bit-per-cycle successor to the serial CRC16 block.
- Computes a CRC over a valid/ready byte (or word) stream, DATA_W bits per clock.
- Generate mode: passes the frame through and appends the CRC as trailing beats.
- Check mode: passes the frame through and flags whether the trailing CRC field was received intact.
- Sits between packet sources/sinks and the link framing logic.

Parameters:
- CRC_W, 16, CRC register width.
- POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted.
- INIT, 16'hFFFF, register value at frame start, after sync and after reset.
- DATA_W, 8, bits consumed per accepted beat. CRC_W must be an integer multiple of DATA_W (elaboration error otherwise).
- XOR_OUT, 16'h0000, XOR applied to the emitted/reported CRC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sync  in  1  synchronous abort: return to IDLE, CRC to INIT, drop any pending output beat.
- mode  in  1  0=generate, 1=check; sampled on the first accepted beat of a frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_data  in  DATA_W  input beat, MSB processed first.
- s_last  in  1  last input beat of frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  output beat.
- m_last  out  1  last output beat of frame.
- crc  out  CRC_W  final CRC (after XOR_OUT), valid with done.
- done  out  1  one-cycle pulse at frame completion.
- crc_ok  out  1  check-mode result, valid with done; 0 in generate mode.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, CRC reg=INIT.
  - s_ready=0 while rst is asserted; 1 from the first clock after release.
  - m_valid=0, m_data=0, m_last=0, crc=0, done=0, crc_ok=0.
- Registers: one output register holds m_data/m_valid/m_last. Pass-through latency is 1 cycle: a beat accepted at edge N is presented on m_* after edge N.
- s_ready = (state!=APPEND) && (!m_valid || m_ready). Output updates only when the register is empty or being drained.
- CRC update: DATA_W-bit unrolled MSB-first LFSR step of POLY, applied once per accepted input beat. No reflection.
- FSM states: IDLE, FRAME, APPEND.
  - IDLE -> FRAME on an accepted beat with s_last=0. mode is latched and the CRC is updated from INIT.
  - IDLE or FRAME, accepted beat with s_last=1:
    - Generate mode: go to APPEND. The pass-through beat has m_last=0. Load the append shifter with final CRC^XOR_OUT.
    - Check mode: go to IDLE. The beat passes with m_last=1. done pulses the same cycle the beat enters the output register. crc_ok = (CRC register after update == 0). crc = that register value.
    - In both modes the CRC register reloads INIT on the next frame start.
  - APPEND: emit CRC_W/DATA_W beats, most-significant chunk first, each advancing only when the output register accepts. The last chunk has m_last=1 and done pulses when it is loaded. crc holds the appended value. Then IDLE.
- Single-beat frame (s_last on the first beat) is legal in both modes.
- done and crc_ok are single-cycle pulses; crc holds its value until the next done.
- sync has priority over a simultaneous accepted beat: the beat is discarded, s_ready is held 0 that cycle, and done is not generated.
- Reset mid-frame or mid-append discards the frame with no done.
- m_data/m_last hold stable while m_valid=1 and m_ready=0.

Optional Feature:
- Macro CRC_ERR_CNT_EN.
- When defined: adds output port err_cnt (16 bits). It increments on each check-mode done with crc_ok=0, saturates at 16'hFFFF, and clears on reset and on sync.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Generate, defaults: ASCII "123456789" (0x31..0x39), m_ready=1 -> 9 pass-through beats, then 0x29, 0xB1 with m_last on 0xB1, done pulse, crc=16'h29B1.
- Check, defaults: "123456789",0x29,0xB1 -> 11 beats out, done with crc_ok=1, crc=0. Flip bit 0 of byte 5 -> crc_ok=0; err_cnt=1 when CRC_ERR_CNT_EN is defined.
- Backpressure: the generate frame above with m_ready toggled 1/0 every cycle and held 0 for 5 cycles during APPEND -> identical output sequence, no dropped or duplicated beats, s_ready=0 throughout APPEND.
- sync: assert sync after 4 beats of a frame, then send "123456789" -> crc=16'h29B1, exactly one done.
- Reset mid-frame: drive rst=0 during APPEND -> m_valid=0 immediately (async), no done; the next frame "123456789" yields 29B1.
- Parametrised instance DATA_W=16, CRC_W=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, XOR_OUT=32'hFFFFFFFF: 4-beat frame 16'h0000 x4 -> 2 appended beats, m_last on the second, crc equal to the bit-serial reference model.

Source files
------------

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream_engine
// Description : Streaming CRC engine that consumes DATA_W bits per accepted
//               beat. In generate mode the frame passes through and the CRC
//               is appended as trailing beats. In check mode the frame passes
//               through and the residue is tested for zero.
//               Optional feature macro: CRC_ERR_CNT_EN adds a saturating
//               err_cnt output that counts failed check-mode frames.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_stream_engine #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CRC_W-1:0]  crc,
    output logic              done,
    output logic              crc_ok
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int NCHUNK = CRC_W / DATA_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FRAME  = 2'd1;
    localparam logic [1:0] ST_APPEND = 2'd2;

    generate
        if ((CRC_W % DATA_W) != 0) begin : g_bad_cfg
            $error("crc_stream_engine: CRC_W must be a multiple of DATA_W");
        end
    endgenerate

    // One MSB-first LFSR step per data bit, unrolled across the whole beat.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = r << 1;
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              mode_q, mode_d;
    logic              rdy_q;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [CRC_W-1:0]  crc_out_q, crc_out_d;
    logic              done_q, done_d;
    logic              crc_ok_q, crc_ok_d;
    logic [CRC_W-1:0]  app_sh_q, app_sh_d;
    logic [CRC_W-1:0]  app_val_q, app_val_d;
    logic [CNT_W-1:0]  app_cnt_q, app_cnt_d;
`ifdef CRC_ERR_CNT_EN
    logic [15:0]       err_q, err_d;
`endif

    logic              w_out_free;
    logic              w_acc;
    logic              w_mode;
    logic [CRC_W-1:0]  w_crc_new;

    // The CRC register sits at INIT whenever the FSM is idle, so the
    // per-beat update never needs a separate frame-start path.
    assign w_out_free = !m_valid_q || m_ready;
    assign s_ready    = rdy_q && !sync && (state_q != ST_APPEND) && w_out_free;
    assign w_acc      = s_valid && s_ready;
    assign w_mode     = (state_q == ST_IDLE) ? mode : mode_q;
    assign w_crc_new  = crc_step(crc_q, s_data);

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign crc     = crc_out_q;
    assign done    = done_q;
    assign crc_ok  = crc_ok_q;
`ifdef CRC_ERR_CNT_EN
    assign err_cnt = err_q;
`endif

    // Next-state logic: FSM, CRC update, output register and append shifter.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        mode_d    = mode_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        crc_out_d = crc_out_q;
        done_d    = 1'b0;
        crc_ok_d  = 1'b0;
        app_sh_d  = app_sh_q;
        app_val_d = app_val_q;
        app_cnt_d = app_cnt_q;
`ifdef CRC_ERR_CNT_EN
        err_d     = err_q;
`endif
        if (sync) begin
            state_d   = ST_IDLE;
            crc_d     = INIT;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
`ifdef CRC_ERR_CNT_EN
            err_d     = 16'h0000;
`endif
        end else begin
            if (m_valid_q && m_ready) m_valid_d = 1'b0;
            if (w_acc) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                m_last_d  = 1'b0;
                if (state_q == ST_IDLE) mode_d = mode;
                if (!s_last) begin
                    state_d = ST_FRAME;
                    crc_d   = w_crc_new;
                end else if (!w_mode) begin
                    state_d   = ST_APPEND;
                    crc_d     = INIT;
                    app_sh_d  = w_crc_new ^ XOR_OUT;
                    app_val_d = w_crc_new ^ XOR_OUT;
                    app_cnt_d = '0;
                end else begin
                    state_d   = ST_IDLE;
                    crc_d     = INIT;
                    m_last_d  = 1'b1;
                    done_d    = 1'b1;
                    crc_ok_d  = (w_crc_new == '0);
                    crc_out_d = w_crc_new;
`ifdef CRC_ERR_CNT_EN
                    if ((w_crc_new != '0) && (err_q != 16'hFFFF)) err_d = err_q + 16'h0001;
`endif
                end
            end else if ((state_q == ST_APPEND) && w_out_free) begin
                m_valid_d = 1'b1;
                m_data_d  = app_sh_q[CRC_W-1 -: DATA_W];
                m_last_d  = 1'b0;
                app_sh_d  = app_sh_q << DATA_W;
                app_cnt_d = app_cnt_q + ONE_CNT;
                if (app_cnt_q == LAST_CNT) begin
                    m_last_d  = 1'b1;
                    done_d    = 1'b1;
                    crc_out_d = app_val_q;
                    state_d   = ST_IDLE;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= INIT;
            mode_q    <= 1'b0;
            rdy_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            crc_out_q <= '0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            app_sh_q  <= '0;
            app_val_q <= '0;
            app_cnt_q <= '0;
`ifdef CRC_ERR_CNT_EN
            err_q     <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            mode_q    <= mode_d;
            rdy_q     <= 1'b1;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            crc_out_q <= crc_out_d;
            done_q    <= done_d;
            crc_ok_q  <= crc_ok_d;
            app_sh_q  <= app_sh_d;
            app_val_q <= app_val_d;
            app_cnt_q <= app_cnt_d;
`ifdef CRC_ERR_CNT_EN
            err_q     <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_stream_engine
// Description : Self-checking bench for crc_stream_engine (default 8/16-bit
//               instance plus a 16/32-bit instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync = 1'b0;
    logic        mode = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] crc;
    logic        done;
    logic        crc_ok;
`ifdef CRC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    logic        s_valid2 = 1'b0;
    logic        s_ready2;
    logic [15:0] s_data2 = 16'h0000;
    logic        s_last2 = 1'b0;
    logic        m_valid2;
    logic [15:0] m_data2;
    logic        m_last2;
    logic [31:0] crc2;
    logic        done2;
    logic        crc_ok2;

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk(clk), .rst(rst), .sync(sync), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .crc(crc), .done(done), .crc_ok(crc_ok)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    crc_stream_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .DATA_W(16), .XOR_OUT(32'hFFFFFFFF)
    ) dut32 (
        .clk(clk), .rst(rst), .sync(1'b0), .mode(1'b0),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
        .m_valid(m_valid2), .m_ready(1'b1), .m_data(m_data2), .m_last(m_last2),
        .crc(crc2), .done(done2), .crc_ok(crc_ok2)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt()
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference: one MSB-first shift per input bit.
    function automatic logic [31:0] ref_bit(input logic [31:0] c, input logic b,
                                           input int cw, input logic [31:0] poly);
        logic [31:0] mask;
        logic        fb;
        mask = (cw == 32) ? 32'hFFFFFFFF : ((32'h1 << cw) - 32'h1);
        fb   = c[cw-1] ^ b;
        c    = (c << 1) & mask;
        if (fb) c = c ^ poly;
        return c;
    endfunction

    typedef struct {
        logic        md;
        int          n;
        logic [7:0]  b [0:10];
        logic [15:0] exp_crc;
        logic        exp_ok;
        logic        bp;
    } vec_t;

    function automatic logic [15:0] ref16(input vec_t v);
        logic [31:0] c;
        c = 32'h0000FFFF;
        for (int i = 0; i < v.n; i++)
            for (int k = 7; k >= 0; k--)
                c = ref_bit(c, v.b[i][k], 16, 32'h00001021);
        return c[15:0];
    endfunction

    // Scoreboard queues: output beats {last,data} and done results {ok,crc}.
    logic [8:0]  exp_q [$];
    logic [16:0] done_q [$];
    logic        sb_en   = 1'b1;
    logic        hold    = 1'b0;
    logic        bp_tog  = 1'b0;
    int          done_cnt = 0;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (hold) m_ready = 1'b0;
            else if (bp_tog) m_ready = ~m_ready;
            else m_ready = 1'b1;
        end
    end

    initial begin
        logic [8:0]  e;
        logic [16:0] d;
        forever begin
            @(negedge clk);
            if (sb_en && m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", {23'd0, m_last, m_data}, 32'h1FF);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", {23'd0, m_last, m_data}, {23'd0, e});
                end
            end
            if (done) begin
                done_cnt++;
                if (sb_en) begin
                    if (done_q.size() == 0) chk("extra_done", 32'd1, 32'd0);
                    else begin
                        d = done_q.pop_front();
                        chk("done_crc", {16'd0, crc}, {16'd0, d[15:0]});
                        chk("done_ok", {31'd0, crc_ok}, {31'd0, d[16]});
                    end
                end
            end
        end
    end

    logic [16:0] cap2 [$];
    int          d2cnt = 0;
    logic [31:0] d2crc = 32'd0;
    initial forever begin
        @(negedge clk);
        if (m_valid2) cap2.push_back({m_last2, m_data2});
        if (done2) begin d2cnt++; d2crc = crc2; end
    end

    // Offer one beat and wait (bounded) until it is accepted.
    task automatic drive_beat(input logic [7:0] d, input logic l);
        logic acc;
        s_valid = 1'b1; s_data = d; s_last = l;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic push_expect(input vec_t v);
        for (int i = 0; i < v.n; i++)
            exp_q.push_back({(v.md && i == v.n - 1), v.b[i]});
        if (!v.md) begin
            exp_q.push_back({1'b0, v.exp_crc[15:8]});
            exp_q.push_back({1'b1, v.exp_crc[7:0]});
        end
        done_q.push_back({v.exp_ok, v.exp_crc});
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || done_q.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_beats", exp_q.size(), 32'd0);
        chk("drain_done", done_q.size(), 32'd0);
        exp_q.delete(); done_q.delete();
    endtask

    task automatic send_frame(input vec_t v);
        mode = v.md;
        bp_tog = v.bp;
        for (int i = 0; i < v.n; i++) begin
            drive_beat(v.b[i], i == v.n - 1);
            if (i == v.n - 1 && v.bp && !v.md) begin
                hold = 1'b1; m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk); chk("s_ready_append", {31'd0, s_ready}, 32'd0);
                    @(posedge clk); #1;
                end
                hold = 1'b0;
            end
        end
    endtask

    vec_t vecs [0:5];
    vec_t v29;
    int   exp_err;
    int   dc0;

    initial begin
        for (int k = 0; k < 6; k++) begin
            vecs[k].n = 9; vecs[k].md = 1'b0; vecs[k].bp = 1'b0;
            for (int i = 0; i < 11; i++) vecs[k].b[i] = 8'h31 + 8'(i);
        end
        vecs[0].exp_crc = 16'h29B1; vecs[0].exp_ok = 1'b0;
        vecs[1].md = 1'b1; vecs[1].n = 11; vecs[1].b[9] = 8'h29; vecs[1].b[10] = 8'hB1;
        vecs[1].exp_crc = 16'h0000; vecs[1].exp_ok = 1'b1;
        vecs[2] = vecs[1]; vecs[2].b[4] = 8'h34;
        vecs[2].exp_crc = ref16(vecs[2]); vecs[2].exp_ok = 1'b0;
        vecs[3].exp_crc = 16'h29B1; vecs[3].exp_ok = 1'b0; vecs[3].bp = 1'b1;
        vecs[4].n = 1; vecs[4].b[0] = 8'h00;
        vecs[4].exp_crc = ref16(vecs[4]); vecs[4].exp_ok = 1'b0;
        vecs[5] = vecs[4]; vecs[5].md = 1'b1;
        vecs[5].exp_ok = (vecs[5].exp_crc == 16'h0000);
        v29 = vecs[0];

        // Reset state while rst is held low.
        #12;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_crc", {16'd0, crc}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("s_ready_after_rst", {31'd0, s_ready}, 32'd1);

        exp_err = 0;
        for (int k = 0; k < 6; k++) begin
            push_expect(vecs[k]);
            send_frame(vecs[k]);
            bp_tog = 1'b0;
            drain();
            if (vecs[k].md && !vecs[k].exp_ok) exp_err++;
        end
        chk("done_count_vectors", done_cnt, 32'd6);
`ifdef CRC_ERR_CNT_EN
        chk("err_cnt", {16'd0, err_cnt}, exp_err);
`endif

        // sync after four beats, with a competing beat offered during sync.
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 8'h41 + 8'(i)});
            drive_beat(8'h41 + 8'(i), 1'b0);
        end
        sync = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        @(negedge clk); chk("s_ready_sync", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        sync = 1'b0; s_valid = 1'b0;
        dc0 = done_cnt;
        push_expect(v29);
        send_frame(v29);
        drain();
        chk("sync_one_done", done_cnt - dc0, 32'd1);

        // Reset while the frame is in APPEND.
        sb_en = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 9; i++) drive_beat(8'h31 + 8'(i), i == 8);
        hold = 1'b1; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        dc0 = done_cnt;
        @(negedge clk); #1;
        rst = 1'b0; #1;
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1; hold = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("midrst_no_done", done_cnt - dc0, 32'd0);
        sb_en = 1'b1;
        push_expect(v29);
        send_frame(v29);
        drain();

        // 32-bit CRC instance, 16-bit beats: four zero words.
        begin
            logic [31:0] c32;
            logic        acc;
            c32 = 32'hFFFFFFFF;
            for (int i = 0; i < 64; i++) c32 = ref_bit(c32, 1'b0, 32, 32'h04C11DB7);
            c32 = c32 ^ 32'hFFFFFFFF;
            cap2.delete(); d2cnt = 0;
            for (int i = 0; i < 4; i++) begin
                s_valid2 = 1'b1; s_data2 = 16'h0000; s_last2 = (i == 3);
                acc = 1'b0;
                for (int j = 0; j < 50 && !acc; j++) begin
                    @(negedge clk); acc = s_ready2;
                    @(posedge clk); #1;
                end
                if (!acc) chk("w32_accept_timeout", 32'd0, 32'd1);
            end
            s_valid2 = 1'b0; s_last2 = 1'b0;
            repeat (6) @(posedge clk); #1;
            chk("w32_beats", cap2.size(), 32'd6);
            if (cap2.size() == 6) begin
                chk("w32_pass3", {15'd0, cap2[3]}, 32'd0);
                chk("w32_app_hi", {15'd0, cap2[4]}, {16'd0, c32[31:16]});
                chk("w32_app_lo", {15'd0, cap2[5]}, {15'd0, 1'b1, c32[15:0]});
            end
            chk("w32_done_cnt", d2cnt, 32'd1);
            chk("w32_crc", d2crc, c32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
